rt_out_stage: RTL and testbench
===============================

# rt_out_stage

Downstream consumer of the RT4 round-transform stage. Each time RT4 delivers an updated 512-bit state, this block takes one message block and derives a 128-bit keystream from the state. It outputs the ciphertext block through a valid/ready handshake. It also accumulates a running tag over the ciphertext and emits the final 128-bit tag after the last block, masking partial final blocks by byte count.

## Interface
- CNT_W, 32, width of block counter `blk_cnt`
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; opens a new message; ignored unless IDLE
- s_valid  in  1  `state_in`/`m_in`/`m_last`/`m_bytes` valid
- s_ready  out  1  block can accept a state+message pair
- state_in  in  512  RT4 output state; S0=[0:127], S1=[128:255], S2=[256:383], S3=[384:511]
- m_in  in  128  message block, big-endian; byte k = bits [8k:8k+7]
- m_last  in  1  this block is final
- m_bytes  in  5  valid bytes in final block; 0 or >16 treated as 16; ignored (16) when m_last=0
- c_valid  out  1  `c_out` valid
- c_ready  in  1  downstream accepts `c_out`
- c_out  out  128  ciphertext block
- c_last  out  1  `c_out` is final block
- tag_valid  out  1  one-cycle pulse, `tag_out` just updated
- tag_out  out  128  final tag; held until next `start`
- blk_cnt  out  CNT_W  blocks accepted this message; saturates at all-ones
- busy  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, ACCEPT, EMIT, TAG.
- IDLE: `s_ready`=0.
  - `start`=1: clear `tag_acc`, `blk_cnt`, `tag_out`; go to ACCEPT.
- ACCEPT: `s_ready`=1.
  - On `s_valid & s_ready`:
    - KS = S1 ^ S3 ^ (S0 & S2)
    - mask = bytes 0..n-1 all-ones, rest zero, where n = effective byte count
    - C = (m_in ^ KS) & mask
    - register `c_out`=C and `c_last`=`m_last`
    - `tag_acc` ^= C
    - save T = S1 ^ S2
    - increment `blk_cnt` (saturating)
    - go to EMIT.
- EMIT: `c_valid`=1 and `s_ready`=0. `c_out` and `c_last` stay stable until `c_ready`.
  - On `c_valid & c_ready`: go to TAG if `c_last`, else go to ACCEPT.
- TAG:
  - `tag_out` = `tag_acc` ^ T, using the T saved from the last block.
  - `tag_valid`=1 for exactly this cycle.
  - Next cycle go to IDLE.
- `start` is ignored in ACCEPT, EMIT and TAG.
- `s_valid` is ignored outside ACCEPT.
- `c_ready` is ignored outside EMIT.
- Non-final blocks always use the full 16-byte mask.
- Reset asserted in any state: the FSM returns to IDLE and all registers take their reset values. No partial output appears after reset release.

## Timing
- Reset values: `s_ready`=0, `c_valid`=0, `c_out`=0, `c_last`=0, `tag_valid`=0, `tag_out`=0, `blk_cnt`=0, `busy`=0.
- All outputs are registered or decoded from the FSM state; there is no combinational path from inputs to outputs.
- `start` sampled at edge n: `s_ready`=1 and `busy`=1 from n+1.
- Accept at edge k: `c_valid`=1 with valid `c_out` from k+1; `blk_cnt` updated at k+1.
- Output handshake at edge j:
  - non-final block: `s_ready`=1 at j+1.
  - final block: `tag_valid`=1 at j+1, `busy`=0 at j+2.
- Peak throughput is one block per 2 cycles, which is ample against RT4's 14-cycle round.
- Backpressure: while `c_ready`=0 in EMIT, `c_valid` stays high, `c_out` stays unchanged and `s_ready` stays 0.

## Test plan
- Full-block keystream: `start`; S0=S2=S3=0, S1=0x0123456789ABCDEF_FEDCBA9876543210, m_in=0, m_last=1 -> `c_out`=S1; `tag_out`=S1^S1=0; `tag_valid` is a single pulse; `blk_cnt`=1.
- AND term and masking: S0=S2=all-ones, S1=S3=0, m_in=0x000...0F, m_last=1, m_bytes=3 -> KS=all-ones; `c_out`=0xFFFFFF followed by 13 zero bytes; `tag_out`=0xFFFFFF000...0 ^ all-ones = 0x000000FF...FF.
- Two-block message: block 1 with S1=A, m_in=0; block 2 with S1=B, m_in=0, m_last=1 (other words 0) -> `c_out` A then B, `c_last` only on the second; `tag_out`=A^B^B=A; `blk_cnt`=2.
- Backpressure: hold `c_ready`=0 for 5 cycles after accept -> `c_out` stable, `c_valid`=1, `s_ready`=0 throughout; completes on the cycle `c_ready` rises.
- Edge inputs:
  - m_bytes=0 and m_bytes=20 on the last block behave as 16 bytes.
  - m_bytes=5 with m_last=0 still gives the full mask.
  - `start` pulsed during EMIT has no effect.
- Reset mid-operation: drop `rst` while in EMIT with `c_valid`=1 -> all outputs 0 immediately; after release the FSM is IDLE and a fresh `start` runs the first scenario correctly.

Source files
------------

// File: rtl/rt_out_stage_if.sv
// rt_out_stage_if: state+message input stream and ciphertext output stream
interface rt_out_stage_if;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] state_in;
    logic [127:0] m_in;
    logic         m_last;
    logic [4:0]   m_bytes;
    logic         c_valid;
    logic         c_ready;
    logic [127:0] c_out;
    logic         c_last;
    modport slave (
        input  s_valid, state_in, m_in, m_last, m_bytes, c_ready,
        output s_ready, c_valid, c_out, c_last
    );
    modport master (
        output s_valid, state_in, m_in, m_last, m_bytes, c_ready,
        input  s_ready, c_valid, c_out, c_last
    );
endinterface

// File: rtl/rt_out_stage.sv
// rt_out_stage: keystream-XOR of message blocks from RT4 state, with running tag over the ciphertext
module rt_out_stage #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    rt_out_stage_if.slave     io,
    output logic              tag_valid,
    output logic [127:0]      tag_out,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCEPT, EMIT, TAG} state_t;
    state_t       state;
    logic [127:0] s0, s1, s2, s3, ks, mask, c_nxt, tag_acc, t_save;
    logic [4:0]   n;
    logic [6:0]   sh;
    assign s0 = io.state_in[511:384];
    assign s1 = io.state_in[383:256];
    assign s2 = io.state_in[255:128];
    assign s3 = io.state_in[127:0];
    assign ks = s1 ^ s3 ^ (s0 & s2);
    // byte 0 is the MSB byte, so keeping n bytes means clearing the low 16-n bytes
    assign n = (io.m_last && io.m_bytes != 5'd0 && io.m_bytes <= 5'd16) ? io.m_bytes : 5'd16;
    assign sh = {4'(5'd16 - n), 3'b000};
    assign mask = {128{1'b1}} << sh;
    assign c_nxt = (io.m_in ^ ks) & mask;
    assign io.s_ready = state == ACCEPT;
    assign io.c_valid = state == EMIT;
    assign tag_valid = state == TAG;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            io.c_out  <= '0;
            io.c_last <= 1'b0;
            tag_out   <= '0;
            tag_acc   <= '0;
            t_save    <= '0;
            blk_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tag_acc <= '0;
                    blk_cnt <= '0;
                    tag_out <= '0;
                    state   <= ACCEPT;
                end
                ACCEPT: if (io.s_valid) begin
                    io.c_out  <= c_nxt;
                    io.c_last <= io.m_last;
                    tag_acc   <= tag_acc ^ c_nxt;
                    t_save    <= s1 ^ s2;
                    blk_cnt   <= &blk_cnt ? blk_cnt : blk_cnt + CNT_W'(1);
                    state     <= EMIT;
                end
                // tag is loaded on the way into TAG so it is valid alongside tag_valid
                EMIT: if (io.c_ready) begin
                    if (io.c_last) tag_out <= tag_acc ^ t_save;
                    state <= io.c_last ? TAG : ACCEPT;
                end
                TAG: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rt_out_stage.sv
// tb_rt_out_stage: table vectors, directed corner sequences and randomized messages against a byte-level model
module tb_rt_out_stage;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         tag_valid;
    logic [127:0] tag_out;
    logic [31:0]  blk_cnt;
    logic         busy;
    int checks = 0;
    int errors = 0;
    rt_out_stage_if io();
    rt_out_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .io(io),
        .tag_valid(tag_valid), .tag_out(tag_out), .blk_cnt(blk_cnt), .busy(busy)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [127:0] s0, s1, s2, s3, m;
        logic         last;
        logic [4:0]   bytes;
        logic [127:0] exp_c, exp_tag;
    } vec_t;
    localparam logic [127:0] P    = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] A    = 128'hA5A5_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A;
    localparam logic [127:0] B    = 128'h3C3C_C3C3_0000_FFFF_1111_2222_3333_4444;
    vec_t vecs[4];
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [127:0] model_c(input logic [127:0] s0, s1, s2, s3, m,
                                             input logic last, input logic [4:0] bytes);
        logic [127:0] ks, c;
        int nb;
        ks = s1 ^ s3 ^ (s0 & s2);
        nb = (!last || bytes == 0 || bytes > 16) ? 16 : int'(bytes);
        c = '0;
        for (int k = 0; k < nb; k++) c[127-8*k -: 8] = m[127-8*k -: 8] ^ ks[127-8*k -: 8];
        return c;
    endfunction
    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, io.s_ready, 0);
        chk({tag, "_c_valid"}, io.c_valid, 0);
        chk({tag, "_c_out"}, io.c_out, 0);
        chk({tag, "_c_last"}, io.c_last, 0);
        chk({tag, "_tag_valid"}, tag_valid, 0);
        chk({tag, "_tag_out"}, tag_out, 0);
        chk({tag, "_blk_cnt"}, blk_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_s_ready", io.s_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_tag_clr", tag_out, 0);
        chk("start_cnt_clr", blk_cnt, 0);
    endtask
    task automatic send(input logic [127:0] s0, s1, s2, s3, m, input logic last, input logic [4:0] bytes,
                        input int hold, input logic poke, input logic [127:0] exp_c, exp_tag,
                        input logic [31:0] exp_cnt);
        io.state_in = {s0, s1, s2, s3};
        io.m_in = m;
        io.m_last = last;
        io.m_bytes = bytes;
        io.s_valid = 1'b1;
        @(negedge clk);
        io.s_valid = 1'b0;
        io.state_in = {4{$urandom(), $urandom(), $urandom(), $urandom()}};
        io.m_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("c_valid", io.c_valid, 1);
        chk("c_out", io.c_out, exp_c);
        chk("c_last", io.c_last, last);
        chk("s_ready_emit", io.s_ready, 0);
        chk("blk_cnt", blk_cnt, exp_cnt);
        for (int i = 0; i < hold; i++) begin
            start = poke && i == 0;
            @(negedge clk);
            start = 1'b0;
            chk("bp_c_valid", io.c_valid, 1);
            chk("bp_c_out", io.c_out, exp_c);
            chk("bp_s_ready", io.s_ready, 0);
        end
        io.c_ready = 1'b1;
        @(negedge clk);
        io.c_ready = 1'b0;
        if (!last) begin
            chk("s_ready_next", io.s_ready, 1);
        end else begin
            chk("tag_valid", tag_valid, 1);
            chk("tag_out", tag_out, exp_tag);
            chk("tag_cnt", blk_cnt, exp_cnt);
            @(negedge clk);
            chk("tag_pulse", tag_valid, 0);
            chk("busy_done", busy, 0);
            chk("tag_hold", tag_out, exp_tag);
        end
    endtask
    task automatic run_vec(input vec_t v);
        do_start();
        send(v.s0, v.s1, v.s2, v.s3, v.m, v.last, v.bytes, 0, 1'b0, v.exp_c, v.exp_tag, 1);
    endtask
    initial begin
        io.s_valid = 1'b0;
        io.c_ready = 1'b0;
        io.state_in = '0;
        io.m_in = '0;
        io.m_last = 1'b0;
        io.m_bytes = '0;
        vecs[0] = '{128'h0, P, 128'h0, 128'h0, 128'h0, 1'b1, 5'd16, P, 128'h0};
        vecs[1] = '{ONES, 128'h0, ONES, 128'h0, 128'h0F, 1'b1, 5'd3,
                    128'hFFFFFF00_00000000_00000000_00000000, 128'h000000FF_FFFFFFFF_FFFFFFFF_FFFFFFFF};
        vecs[2] = '{ONES, 128'h0, ONES, 128'h0, 128'h0F, 1'b1, 5'd0, ~128'h0F, 128'h0F};
        vecs[3] = '{ONES, 128'h0, ONES, 128'h0, 128'h0F, 1'b1, 5'd20, ~128'h0F, 128'h0F};
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", io.s_ready, 0);
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);
        // two-block message: tag collapses to A since the last T cancels B
        do_start();
        send(128'h0, A, 128'h0, 128'h0, 128'h0, 1'b0, 5'd0, 0, 1'b0, A, 128'h0, 1);
        send(128'h0, B, 128'h0, 128'h0, 128'h0, 1'b1, 5'd16, 0, 1'b0, B, A, 2);
        // partial count on a non-final block, then backpressure with a stray start
        do_start();
        send(128'h0, A, 128'h0, 128'h0, ONES, 1'b0, 5'd5, 0, 1'b0, ~A, 128'h0, 1);
        send(128'h0, B, 128'h0, 128'h0, 128'h0, 1'b1, 5'd16, 5, 1'b1, B, ~A, 2);
        // reset while holding a block in EMIT
        do_start();
        io.state_in = {128'h0, P, 128'h0, 128'h0};
        io.m_in = '0;
        io.m_last = 1'b1;
        io.m_bytes = 5'd16;
        io.s_valid = 1'b1;
        @(negedge clk);
        io.s_valid = 1'b0;
        chk("pre_rst_c_valid", io.c_valid, 1);
        #2 rst = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_c_valid", io.c_valid, 0);
        run_vec(vecs[0]);
        for (int msg = 0; msg < 20; msg++) begin
            int nblk;
            logic [127:0] acc;
            nblk = $urandom_range(1, 4);
            acc = '0;
            do_start();
            for (int b = 0; b < nblk; b++) begin
                logic [127:0] w0, w1, w2, w3, m, c;
                logic last;
                logic [4:0] bytes;
                w0 = {$urandom(), $urandom(), $urandom(), $urandom()};
                w1 = {$urandom(), $urandom(), $urandom(), $urandom()};
                w2 = {$urandom(), $urandom(), $urandom(), $urandom()};
                w3 = {$urandom(), $urandom(), $urandom(), $urandom()};
                m  = {$urandom(), $urandom(), $urandom(), $urandom()};
                last = b == nblk - 1;
                bytes = 5'($urandom_range(0, 31));
                c = model_c(w0, w1, w2, w3, m, last, bytes);
                acc ^= c;
                send(w0, w1, w2, w3, m, last, bytes, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     c, acc ^ w1 ^ w2, 32'(b + 1));
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
